// File: rtl/gpio_bank.sv
// Multi-port GPIO bank: 2-flop synchronized inputs, per-pin edge interrupts with W1C status, and a single-cycle register bus (ack one cycle after sel_i, no wait states).
// The optional per-pin debounce filter is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_bank #(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 8,
  parameter int DEB_CYC   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sel_i,
  input  logic                        we_i,
  input  logic [7:0]                  addr_i,
  input  logic [31:0]                 wdata_i,
  output logic [31:0]                 rdata_o,
  output logic                        ack_o,
  output logic                        irq_o,
  input  logic [NUM_PORTS*PORT_W-1:0] pad_in_i,
  output logic [NUM_PORTS*PORT_W-1:0] pad_out_o,
  output logic [NUM_PORTS*PORT_W-1:0] pad_oe_o
);

  localparam int N = NUM_PORTS * PORT_W;

  logic [NUM_PORTS-1:0][PORT_W-1:0] dir_q, out_q, ie_q, pol_q, stat_q;
  logic [NUM_PORTS-1:0][PORT_W-1:0] in_2d, in_d_q, stat_set, stat_clr;
  logic [N-1:0]  sync1_q, sync2_q, in_val;
  logic [2:0]    port_idx, reg_idx;
  logic          wr_en;
  logic [31:0]   rd_val, rdata_q;
  logic          ack_q;
  logic          unused_bits;

  assign port_idx = addr_i[7:5];
  assign reg_idx  = addr_i[4:2];
  assign wr_en    = sel_i & we_i;

  // Byte-lane address bits and data bits above PORT_W carry no meaning here.
  assign unused_bits = ^{addr_i[1:0], wdata_i, 32'(DEB_CYC)};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      in_d_q  <= '0;
    end else begin
      sync1_q <= pad_in_i;
      sync2_q <= sync1_q;
      in_d_q  <= in_2d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYC + 1);

  logic [CW-1:0] deb_cnt_q [N];
  logic [N-1:0]  deb_in_q;

  // IN only moves after DEB_CYC consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_in_q <= '0;
      for (int i = 0; i < N; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2_q[i] != deb_in_q[i]) begin
          if (deb_cnt_q[i] == CW'(DEB_CYC - 1)) begin
            deb_in_q[i]  <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + CW'(1);
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign in_val = deb_in_q;
`else
  assign in_val = sync2_q;
`endif

  assign in_2d = in_val;

  // Output pins never raise status; POL picks rising (1) or falling (0).
  assign stat_set = ~dir_q & ((pol_q & in_2d & ~in_d_q) | (~pol_q & ~in_2d & in_d_q));

  always_comb begin
    stat_clr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_en && port_idx == 3'(p) && reg_idx == 3'd5) stat_clr[p] = wdata_i[PORT_W-1:0];
    end
  end

  always_comb begin
    rd_val = '0;
    if (addr_i[7:2] == 6'h3F) begin
      for (int p = 0; p < NUM_PORTS; p++) rd_val[p] = |(stat_q[p] & ie_q[p]);
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_idx == 3'(p)) begin
          case (reg_idx)
            3'd0:    rd_val[PORT_W-1:0] = dir_q[p];
            3'd1:    rd_val[PORT_W-1:0] = out_q[p];
            3'd2:    rd_val[PORT_W-1:0] = in_2d[p];
            3'd3:    rd_val[PORT_W-1:0] = ie_q[p];
            3'd4:    rd_val[PORT_W-1:0] = pol_q[p];
            3'd5:    rd_val[PORT_W-1:0] = stat_q[p];
            default: rd_val = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= '0;
      out_q   <= '0;
      ie_q    <= '0;
      pol_q   <= '1;
      stat_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= sel_i;
      rdata_q <= sel_i ? rd_val : '0;
      // Clear first, then set, so a same-cycle edge wins over W1C.
      stat_q  <= (stat_q & ~stat_clr) | stat_set;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_en && port_idx == 3'(p)) begin
          case (reg_idx)
            3'd0:    dir_q[p] <= wdata_i[PORT_W-1:0];
            3'd1:    out_q[p] <= wdata_i[PORT_W-1:0];
            3'd3:    ie_q[p]  <= wdata_i[PORT_W-1:0];
            3'd4:    pol_q[p] <= wdata_i[PORT_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign irq_o     = |(stat_q & ie_q);
  assign pad_out_o = out_q;
  assign pad_oe_o  = dir_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: register table, interrupt latency and W1C race, reset abort, and debounce when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_bank;

  localparam int NP = 3;
  localparam int PW = 8;
  localparam int N  = NP * PW;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 16;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sel_i, we_i;
  logic [7:0]    addr_i;
  logic [31:0]   wdata_i;
  logic [31:0]   rdata_o;
  logic          ack_o, irq_o;
  logic [N-1:0]  pad_in_i, pad_out_o, pad_oe_o;

  int tests = 0;
  int fails = 0;

  gpio_bank #(.NUM_PORTS(NP), .PORT_W(PW), .DEB_CYC(DEB)) dut (
    .clk(clk), .rst(rst), .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .irq_o(irq_o),
    .pad_in_i(pad_in_i), .pad_out_o(pad_out_o), .pad_oe_o(pad_oe_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the access edge.
  task automatic access(input logic we, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic ak);
    sel_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    @(negedge clk);
    rd = rdata_o;
    ak = ack_o;
    sel_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic ak;
    access(1'b1, a, d, rd, ak);
    check($sformatf("wr_ack_%h", a), 32'(ak), 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic ak;
    access(1'b0, a, 32'h0, rd, ak);
    check({name, "_ack"}, 32'(ak), 32'd1);
    check(name, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic ak;

    vecs[0]  = '{1'b0, 8'h20, 32'h0,        1'b1, 32'h0};
    vecs[1]  = '{1'b0, 8'h30, 32'h0,        1'b1, 32'hFF};
    vecs[2]  = '{1'b1, 8'h20, 32'h04,       1'b0, 32'h0};
    vecs[3]  = '{1'b1, 8'h24, 32'hA5,       1'b0, 32'h0};
    vecs[4]  = '{1'b0, 8'h20, 32'h0,        1'b1, 32'h04};
    vecs[5]  = '{1'b0, 8'h24, 32'h0,        1'b1, 32'hA5};
    vecs[6]  = '{1'b1, 8'h44, 32'hFFFFFF12, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 8'h44, 32'h0,        1'b1, 32'h12};
    vecs[8]  = '{1'b1, 8'h28, 32'h55,       1'b0, 32'h0};
    vecs[9]  = '{1'b0, 8'h28, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 8'h18, 32'hFF,       1'b0, 32'h0};
    vecs[11] = '{1'b0, 8'h18, 32'h0,        1'b1, 32'h0};
    vecs[12] = '{1'b1, 8'h60, 32'h08,       1'b0, 32'h0};
    vecs[13] = '{1'b0, 8'h60, 32'h0,        1'b1, 32'h0};
    vecs[14] = '{1'b1, 8'h4C, 32'h3C,       1'b0, 32'h0};
    vecs[15] = '{1'b0, 8'h4C, 32'h0,        1'b1, 32'h3C};
    vecs[16] = '{1'b0, 8'hFC, 32'h0,        1'b1, 32'h0};
    vecs[17] = '{1'b0, 8'h34, 32'h0,        1'b1, 32'h0};

    rst = 1'b1; sel_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; pad_in_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",    32'(ack_o),     32'd0);
    check("rst_rdata",  rdata_o,        32'd0);
    check("rst_irq",    32'(irq_o),     32'd0);
    check("rst_padout", 32'(pad_out_o), 32'd0);
    check("rst_padoe",  32'(pad_oe_o),  32'd0);
    rst = 1'b0;

    // Back-to-back accesses, the first one in the cycle right after reset release.
    for (int i = 0; i < 18; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, ak);
      check($sformatf("vec%0d_ack", i), 32'(ak), 32'd1);
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end
    @(negedge clk);
    check("idle_ack",   32'(ack_o),     32'd0);
    check("idle_rdata", rdata_o,        32'd0);
    check("pad_oe",     32'(pad_oe_o),  32'h000400);
    check("pad_out",    32'(pad_out_o), 32'h12A500);
    check("irq_idle",   32'(irq_o),     32'd0);

`ifndef GPIO_DEBOUNCE_EN
    wr(8'h0C, 32'h01);
    wr(8'h10, 32'h01);
    pad_in_i[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("irq_k1", 32'(irq_o), 32'd0);
    @(negedge clk);
    check("irq_k2", 32'(irq_o), 32'd1);
    rd_chk("stat0_set", 8'h14, 32'h01);
    rd_chk("in0_high",  8'h08, 32'h01);
    rd_chk("summary1",  8'hFC, 32'h01);
    wr(8'h14, 32'h01);
    check("irq_w1c", 32'(irq_o), 32'd0);
    rd_chk("stat0_clr", 8'h14, 32'h00);

    pad_in_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    rd_chk("stat0_fall_rpol", 8'h14, 32'h00);

    wr(8'h00, 32'h02);
    wr(8'h0C, 32'h03);
    pad_in_i[1] = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("in0_outpin",   8'h08, 32'h02);
    rd_chk("stat0_outpin", 8'h14, 32'h00);
    pad_in_i[1] = 1'b0;

    wr(8'h10, 32'h00);
    rd_chk("stat0_polchg", 8'h14, 32'h00);
    pad_in_i[0] = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("stat0_rise_fpol", 8'h14, 32'h00);
    pad_in_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    rd_chk("stat0_fall_fpol", 8'h14, 32'h01);
    wr(8'h14, 32'h01);
    rd_chk("stat0_clr2", 8'h14, 32'h00);
    wr(8'h10, 32'h01);

    // W1C lands on the same edge that sets the bit: set must win.
    pad_in_i[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(8'h14, 32'h01);
    rd_chk("stat0_race", 8'h14, 32'h01);
    check("irq_race", 32'(irq_o), 32'd1);
`else
    pad_in_i[16] = 1'b1;
    repeat (3) @(negedge clk);
    pad_in_i[16] = 1'b0;
    repeat (8) @(negedge clk);
    rd_chk("in2_glitch",   8'h48, 32'h00);
    rd_chk("stat2_glitch", 8'h54, 32'h00);
    pad_in_i[16] = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk("in2_stable",   8'h48, 32'h01);
    rd_chk("stat2_stable", 8'h54, 32'h01);
    wr(8'h4C, 32'h01);
    check("irq_deb", 32'(irq_o), 32'd1);
`endif

    // Reset asserted in the same cycle as a write aborts it.
    pad_in_i = '0;
    sel_i = 1'b1; we_i = 1'b1; addr_i = 8'h24; wdata_i = 32'h5A; rst = 1'b1;
    @(negedge clk);
    check("abort_ack",    32'(ack_o),     32'd0);
    check("abort_rdata",  rdata_o,        32'd0);
    check("abort_irq",    32'(irq_o),     32'd0);
    check("abort_padout", 32'(pad_out_o), 32'd0);
    check("abort_padoe",  32'(pad_oe_o),  32'd0);
    sel_i = 1'b0; we_i = 1'b0; rst = 1'b0;
    rd_chk("abort_out1", 8'h24, 32'h00);
    rd_chk("abort_pol0", 8'h10, 32'hFF);
    rd_chk("abort_stat", 8'h14, 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
